ifu_fetch_fsm: RTL and testbench

- Next-generation instruction fetch unit. Replaces the free-running PC register with a handshaked fetch engine.
- Issues one instruction-memory request at a time and registers the returned word with its PC.
- Presents the instruction to the decode stage over a valid/ready interface.
- Redirects (jump) may arrive in any state; responses made stale by a redirect are discarded.

---
 rtl/ifu_fetch_fsm.sv | 110 +++++++++++
 tb/tb_ifu_fetch_fsm.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_fsm
// Brief    : Handshaked instruction fetch engine. Issues one memory request
//            at a time, registers the returned word with its PC, and offers
//            it to decode over valid/ready. Redirects may arrive in any
//            state, and responses made stale by a redirect are discarded.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_fsm #(
  parameter int              XLEN     = 32,
  parameter int              INST_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              PC_STEP  = 4,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump,
  input  logic [XLEN-1:0]   jump_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_fault,
  output logic [CNT_W-1:0]  fetch_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_OUT   = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  localparam logic [XLEN-1:0]  PC_INC  = XLEN'(PC_STEP);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            req_fire;
  logic            inst_fire;

  // Handshake outputs decode straight from the registered state.
  assign imem_req_valid = (state == ST_REQ);
  assign inst_valid     = (state == ST_OUT);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign inst_fire      = inst_valid & inst_ready;

  // Fetch sequencer: request, wait for the word, present it, and absorb
  // the single stale response left behind by a redirect after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
      fetch_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_REQ;
          if (jump) pc <= jump_pc;
        end
        ST_REQ: begin
          if (jump) begin
            pc <= jump_pc;
            // An accepted request at the old address still owes a response.
            if (req_fire) state <= ST_FLUSH;
          end else if (req_fire) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (jump) begin
            pc    <= jump_pc;
            state <= imem_rsp_valid ? ST_REQ : ST_FLUSH;
          end else if (imem_rsp_valid) begin
            state      <= ST_OUT;
            inst       <= imem_rsp_data;
            inst_pc    <= pc;
            inst_fault <= imem_rsp_err;
            pc         <= pc + PC_INC;
          end
        end
        ST_OUT: begin
          if (inst_fire) fetch_cnt <= fetch_cnt + CNT_ONE;
          if (inst_fire || jump) state <= ST_REQ;
          if (jump) pc <= jump_pc;
        end
        ST_FLUSH: begin
          if (jump) pc <= jump_pc;
          if (imem_rsp_valid) state <= ST_REQ;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch_fsm
// Brief    : Self-checking bench for ifu_fetch_fsm with a transaction-level
//            reference model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump;
  logic [31:0] jump_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic [31:0] fetch_cnt;

  // second instance: wrapping reset PC and a tiny counter
  logic        b_rst, b_jump, b_req_valid, b_req_ready, b_rsp_valid, b_inst_valid, b_inst_ready, b_inst_fault;
  logic [31:0] b_jump_pc, b_req_addr, b_rsp_data, b_inst, b_inst_pc;
  logic [1:0]  b_fetch_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifu_fetch_fsm u_dut (
    .clk(clk), .rst(rst), .jump(jump), .jump_pc(jump_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .fetch_cnt(fetch_cnt)
  );

  ifu_fetch_fsm #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) u_wrap (
    .clk(clk), .rst(b_rst), .jump(b_jump), .jump_pc(b_jump_pc),
    .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_req_addr(b_req_addr),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data), .imem_rsp_err(1'b0),
    .inst_valid(b_inst_valid), .inst_ready(b_inst_ready), .inst(b_inst), .inst_pc(b_inst_pc),
    .inst_fault(b_inst_fault), .fetch_cnt(b_fetch_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction view) ----------------
  // boot: first cycle after reset; pend: a request is accepted and its
  // response owed; stale: that response must be dropped; hold: an
  // instruction is being offered to decode. Otherwise a request is offered.
  bit          mdl_on = 1'b0;
  bit          m_boot, m_pend, m_stale, m_hold, m_fault;
  logic [31:0] m_pc, m_inst, m_ipc, m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      mdl_on <= 1'b1;
      m_boot <= 1'b1; m_pend <= 1'b0; m_stale <= 1'b0; m_hold <= 1'b0;
      m_pc <= 32'h8000_0000; m_inst <= '0; m_ipc <= '0; m_fault <= 1'b0; m_cnt <= '0;
    end else if (mdl_on) begin
      if (m_boot) begin
        m_boot <= 1'b0;
      end else if (m_hold) begin
        if (inst_ready) begin
          m_cnt  <= m_cnt + 32'd1;
          m_hold <= 1'b0;
        end else if (jump) begin
          m_hold <= 1'b0;
        end
      end else if (m_pend) begin
        if (imem_rsp_valid) begin
          m_pend  <= 1'b0;
          m_stale <= 1'b0;
          if (!m_stale && !jump) begin
            m_hold  <= 1'b1;
            m_inst  <= imem_rsp_data;
            m_ipc   <= m_pc;
            m_fault <= imem_rsp_err;
            m_pc    <= m_pc + 32'd4;
          end
        end else if (jump) begin
          m_stale <= 1'b1;
        end
      end else if (imem_req_ready) begin
        m_pend  <= 1'b1;
        m_stale <= jump;
      end
      if (jump) m_pc <= jump_pc;
    end
  end

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    if (mdl_on) begin
      chk("m_req_valid", imem_req_valid, !m_boot && !m_pend && !m_hold);
      chk("m_req_addr", imem_req_addr, m_pc);
      chk("m_inst_valid", inst_valid, m_hold);
      chk("m_inst", inst, m_inst);
      chk("m_inst_pc", inst_pc, m_ipc);
      chk("m_inst_fault", inst_fault, m_fault);
      chk("m_fetch_cnt", fetch_cnt, m_cnt);
    end
  end

  // ---------------- memory responder for u_dut ----------------
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;
  int          mem_lat = 0;
  bit          force_en = 1'b0;
  logic [31:0] force_val = '0;
  logic [31:0] err_addr = '0;
  bit          rand_err = 1'b0;
  bit          rand_data = 1'b0;

  task automatic step(input logic j, input logic [31:0] jp, input logic rr, input logic ir);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    imem_rsp_err   = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = force_en ? force_val : (rand_data ? $urandom : (mem_addr ^ 32'hFFFF_FFFF));
        imem_rsp_err   = (mem_addr == err_addr) || (rand_err && ($urandom % 4 == 0));
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    jump = j; jump_pc = jp; imem_req_ready = rr; inst_ready = ir;
    if (imem_req_valid && rr) begin
      mem_busy = 1'b1;
      mem_addr = imem_req_addr;
      mem_cnt  = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 3));
    end
  endtask

  task automatic step2(input logic r, input logic rr, input logic rv, input logic [31:0] d, input logic ir);
    @(negedge clk);
    b_rst = r; b_req_ready = rr; b_rsp_valid = rv; b_rsp_data = d; b_inst_ready = ir;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcs [4];
    logic        flt [4];
    logic [31:0] exp_pc, sv_inst, sv_cnt;
    int          n;
    bit          seen;

    rst = 1'b1; jump = 1'b0; jump_pc = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; imem_rsp_err = 1'b0; inst_ready = 1'b0;
    b_rst = 1'b1; b_jump = 1'b0; b_jump_pc = '0; b_req_ready = 1'b0; b_rsp_valid = 1'b0;
    b_rsp_data = '0; b_inst_ready = 1'b0;

    // ---- wrapping reset PC, counter wrap, reset during WAIT ----
    step2(1, 0, 0, 0, 0);
    step2(1, 0, 0, 0, 0);
    chk("w_rst_req_valid", b_req_valid, 0);
    chk("w_rst_inst_valid", b_inst_valid, 0);
    chk("w_rst_addr", b_req_addr, 32'hFFFF_FFFC);
    chk("w_rst_cnt", b_fetch_cnt, 0);
    step2(0, 0, 0, 0, 0);
    exp_pc = 32'hFFFF_FFFC;
    for (int k = 0; k < 5; k++) begin
      step2(0, 1, 0, 0, 0);
      chk("w_req_valid", b_req_valid, 1);
      chk("w_req_addr", b_req_addr, exp_pc);
      if (k == 1) chk("w_wrap_addr", b_req_addr, 32'h0000_0000);
      step2(0, 0, 1, 32'(k), 0);
      step2(0, 0, 0, 0, 1);
      chk("w_inst_valid", b_inst_valid, 1);
      chk("w_inst_pc", b_inst_pc, exp_pc);
      chk("w_inst", b_inst, 32'(k));
      exp_pc = exp_pc + 32'd4;
    end
    step2(0, 0, 0, 0, 0);
    chk("w_cnt_wrap", b_fetch_cnt, 2'd1);
    chk("w_addr_after", b_req_addr, 32'h0000_0010);
    step2(0, 1, 0, 0, 0);
    step2(1, 0, 0, 0, 0);
    step2(0, 0, 1, 32'h1234, 0);
    chk("w_rw_req_valid", b_req_valid, 0);
    chk("w_rw_inst_valid", b_inst_valid, 0);
    chk("w_rw_inst", b_inst, 0);
    chk("w_rw_inst_pc", b_inst_pc, 0);
    chk("w_rw_cnt", b_fetch_cnt, 0);
    chk("w_rw_addr", b_req_addr, 32'hFFFF_FFFC);
    step2(0, 0, 1, 32'h55, 0);
    chk("w_post_req", b_req_valid, 1);
    chk("w_post_inst_valid", b_inst_valid, 0);
    chk("w_post_addr", b_req_addr, 32'hFFFF_FFFC);
    step2(0, 0, 0, 0, 0);
    chk("w_ign_req", b_req_valid, 1);
    chk("w_ign_inst_valid", b_inst_valid, 0);

    // ---- main instance: reset and straight-line fetch ----
    mem_lat = 0; err_addr = 32'h8000_0008;
    step(0, 0, 1, 1); step(0, 0, 1, 1); step(0, 0, 1, 1);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_cnt", fetch_cnt, 0);
    chk("rst_inst", inst, 0);
    rst = 1'b0;
    step(0, 0, 1, 1);
    chk("first_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0000});
    n = 0;
    for (int b = 0; b < 40 && n < 4; b++) begin
      step(0, 0, 1, 1);
      if (inst_valid) begin
        if (n == 3) chk("cnt_after_3", fetch_cnt, 3);
        pcs[n] = inst_pc; flt[n] = inst_fault;
        n++;
      end
    end
    chk("seq_timeout", n, 4);
    chk("seq_pc0", pcs[0], 32'h8000_0000);
    chk("seq_pc1", pcs[1], 32'h8000_0004);
    chk("seq_pc2", pcs[2], 32'h8000_0008);
    chk("fault_pc0", flt[0], 0);
    chk("fault_pc8", flt[2], 1);
    chk("fault_next", flt[3], 0);

    // ---- redirect while the request is not accepted ----
    for (int i = 0; i < 5; i++) begin
      step(i == 1, 32'h8000_0100, 0, 1);
      if (i >= 2) chk("stall_addr", imem_req_addr, 32'h8000_0100);
      chk("stall_no_fire", mem_busy, 0);
    end
    mem_lat = 2; force_en = 1'b1; force_val = 32'hDEAD_BEEF;
    step(0, 0, 1, 1);
    chk("accept_addr", mem_addr, 32'h8000_0100);

    // ---- redirect in WAIT, late stale response ----
    step(1, 32'h8000_0200, 0, 0);
    seen = 1'b0;
    for (int b = 0; b < 8 && !seen; b++) begin
      step(0, 0, 0, 0);
      chk("stale_not_shown", inst_valid, 0);
      seen = imem_req_valid;
    end
    chk("flush_req", seen, 1);
    chk("flush_addr", imem_req_addr, 32'h8000_0200);
    force_en = 1'b0; mem_lat = 0;

    // ---- decode back-pressure, then redirect without handshake ----
    step(0, 0, 1, 0);
    seen = 1'b0;
    for (int b = 0; b < 6 && !seen; b++) begin
      step(0, 0, 0, 0);
      seen = inst_valid;
    end
    chk("bp_seen", seen, 1);
    chk("bp_inst_pc", inst_pc, 32'h8000_0200);
    chk("bp_inst", inst, 32'h7FFF_FDFF);
    sv_inst = inst; sv_cnt = fetch_cnt;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("bp_valid", inst_valid, 1);
      chk("bp_stable", inst, sv_inst);
      chk("bp_no_req", imem_req_valid, 0);
    end
    step(1, 32'h8000_0300, 0, 0);
    step(0, 0, 0, 0);
    chk("drop_valid", inst_valid, 0);
    chk("drop_cnt", fetch_cnt, sv_cnt);
    chk("drop_addr", {imem_req_valid, imem_req_addr}, {1'b1, 32'h8000_0300});

    // ---- randomized traffic against the model ----
    mem_lat = -1; rand_err = 1'b1; rand_data = 1'b1; err_addr = '0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom % 8 == 0,
           ($urandom % 3 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom,
           $urandom % 2 == 0, $urandom % 5 < 3);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
